sll_walker: RTL

- Hardware initiator for the singly linked list op/op_start/op_done command interface; it is the reader counterpart of the list.
- On a host start it walks the list from head by following next_node_addr, issuing only Read ops (op=3'b000).
- Full mode streams every node's data out over a valid/ready port.
- Find mode stops at the first node whose data matches a value and reports its index.
- Sits between a host or control FSM and one singly linked list instance.

---
 rtl/sll_walker_if.sv | 35 +++
 rtl/sll_walker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sll_walker_if.sv
// sll_walker_if: list command bus plus node-data stream.
// master = walker side, slave = list model / stream sink side.
interface sll_walker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [2:0]            ll_op;
  logic                  ll_op_start;
  logic [ADDR_WIDTH-1:0] ll_addr_in;
  logic [DATA_WIDTH-1:0] ll_data_in;
  logic [DATA_WIDTH-1:0] ll_data_out;
  logic                  ll_op_done;
  logic [ADDR_WIDTH-1:0] ll_next_node_addr;
  logic [ADDR_WIDTH-1:0] ll_head;
  logic                  ll_empty;
  logic                  ll_fault;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output ll_op, ll_op_start, ll_addr_in, ll_data_in,
    output m_data, m_valid, m_last,
    input  ll_data_out, ll_op_done, ll_next_node_addr,
    input  ll_head, ll_empty, ll_fault, m_ready
  );

  modport slave (
    input  ll_op, ll_op_start, ll_addr_in, ll_data_in,
    input  m_data, m_valid, m_last,
    output ll_data_out, ll_op_done, ll_next_node_addr,
    output ll_head, ll_empty, ll_fault, m_ready
  );
endinterface

// File: rtl/sll_walker.sv
// sll_walker: walks a singly linked list from head using Read ops,
// streaming node data (stream mode) or locating a value (find mode).
// Ports: clk, rst (async active-low); start/find_en/find_value in;
// busy/done/found/found_index/count/err out; bus = list cmd + stream.
module sll_walker #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_NODE    = 8,
  parameter int TIMEOUT_CYC = 64,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  find_en,
  input  logic [DATA_WIDTH-1:0] find_value,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] found_index,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  err,
  sll_walker_if.master          bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL =
    ADDR_WIDTH'(MAX_NODE + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_C = ADDR_WIDTH'(MAX_NODE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, EMIT, DONE
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH-1:0] next_q, next_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic [ADDR_WIDTH-1:0] fidx, fidx_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [DATA_WIDTH-1:0] fval, fval_n;
  logic [TW-1:0]         tmo, tmo_n;
  logic                  fen, fen_n;
  logic                  found_q, found_n;
  logic                  err_q, err_n;
  logic                  ops_q, ops_n;

  assign cnt_inc = cnt + ADDR_WIDTH'(1);

  always_comb begin
    state_n = state;
    addr_n  = addr;
    next_n  = next_q;
    cnt_n   = cnt;
    fidx_n  = fidx;
    data_n  = data_q;
    fval_n  = fval;
    tmo_n   = tmo;
    fen_n   = fen;
    found_n = found_q;
    err_n   = err_q;
    ops_n   = ops_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          fen_n   = find_en;
          fval_n  = find_value;
          cnt_n   = '0;
          found_n = 1'b0;
          fidx_n  = '0;
          err_n   = 1'b0;
          if (bus.ll_empty) begin
            state_n = DONE;
          end else begin
            addr_n  = bus.ll_head;
            state_n = ISSUE;
          end
        end
      end
      // The strobe is registered, so ISSUE doubles as the
      // mandatory low gap between back-to-back ops.
      ISSUE: begin
        tmo_n   = '0;
        ops_n   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (bus.ll_op_done) begin
          ops_n  = 1'b0;
          data_n = bus.ll_data_out;
          next_n = bus.ll_next_node_addr;
          cnt_n  = cnt_inc;
          if (bus.ll_fault) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else if (!fen) begin
            state_n = EMIT;
          end else if (bus.ll_data_out == fval) begin
            found_n = 1'b1;
            fidx_n  = cnt;
            state_n = DONE;
          end else if (bus.ll_next_node_addr == ADDR_NULL) begin
            state_n = DONE;
          end else if (cnt_inc == MAX_C) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            addr_n  = bus.ll_next_node_addr;
            state_n = ISSUE;
          end
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          ops_n   = 1'b0;
          state_n = DONE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          if (next_q == ADDR_NULL) begin
            state_n = DONE;
          end else if (cnt == MAX_C) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            addr_n  = next_q;
            state_n = ISSUE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      next_q  <= '0;
      cnt     <= '0;
      fidx    <= '0;
      data_q  <= '0;
      fval    <= '0;
      tmo     <= '0;
      fen     <= 1'b0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      ops_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      next_q  <= next_n;
      cnt     <= cnt_n;
      fidx    <= fidx_n;
      data_q  <= data_n;
      fval    <= fval_n;
      tmo     <= tmo_n;
      fen     <= fen_n;
      found_q <= found_n;
      err_q   <= err_n;
      ops_q   <= ops_n;
    end
  end

  assign busy        = (state == ISSUE) || (state == WAIT) ||
                       (state == EMIT);
  assign done        = (state == DONE);
  assign found       = found_q;
  assign found_index = fidx;
  assign count       = cnt;
  assign err         = err_q;

  assign bus.ll_op       = 3'b000;
  assign bus.ll_data_in  = '0;
  assign bus.ll_op_start = ops_q;
  assign bus.ll_addr_in  = addr;
  assign bus.m_valid     = (state == EMIT);
  assign bus.m_data      = data_q;
  assign bus.m_last      = (state == EMIT) && (next_q == ADDR_NULL);

endmodule
